// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - result record stream between the sweeper and its consumer
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    logic            res_valid;
    logic            res_ready;
    logic [N_IN-1:0] res_idx;
    logic            res_y;
    logic            res_exp;

    modport master (
        output res_valid,
        output res_idx,
        output res_y,
        output res_exp,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_idx,
        input  res_y,
        input  res_exp,
        output res_ready
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep of a combinational cell with result stream
module truth_table_sweeper #(
    parameter int                   N_IN   = 4,
    parameter int                   SETTLE = 2,
    parameter logic [2**N_IN-1:0]   EXPECT = 16'h0777
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_IN-1:0]     stim,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_count,
    output logic [N_IN-1:0]     first_fail_idx,
    output logic                first_fail_vld,
    truth_table_sweeper_if.master res
);

    // Counter only has to hold SETTLE-1; keep at least one bit.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_REPORT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [N_IN-1:0] idx;

    logic            accept;
    logic            sample;
    logic            handshake;
    logic            last_vec;
    logic            exp_bit;
    logic            mismatch;

    // Expected value for the vector currently on stim; X/Z on dut_y is a mismatch.
    always_comb begin
        exp_bit  = EXPECT[idx];
        mismatch = (dut_y !== exp_bit);
        last_vec = (idx == IDX_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle event strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        handshake = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res.res_valid && res.res_ready) begin
                    handshake = 1'b1;
                    state_nxt = last_vec ? S_IDLE : S_SETTLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector index, settle counter, result record and summary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx            <= '0;
            cnt            <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            res.res_valid  <= 1'b0;
            res.res_idx    <= '0;
            res.res_y      <= 1'b0;
            res.res_exp    <= 1'b0;
        end else begin
            if (accept) begin
                idx            <= '0;
                stim           <= '0;
                cnt            <= CNT_LOAD;
                busy           <= 1'b1;
                done           <= 1'b0;
                pass           <= 1'b0;
                err_count      <= '0;
                first_fail_idx <= '0;
                first_fail_vld <= 1'b0;
            end

            if (state == S_SETTLE && cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end

            if (sample) begin
                res.res_valid <= 1'b1;
                res.res_idx   <= idx;
                res.res_y     <= dut_y;
                res.res_exp   <= exp_bit;
                if (mismatch) begin
                    err_count <= err_count + ERR_ONE;
                    if (!first_fail_vld) begin
                        first_fail_idx <= idx;
                        first_fail_vld <= 1'b1;
                    end
                end
            end

            if (handshake) begin
                res.res_valid <= 1'b0;
                if (last_vec) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == '0);
                    stim <= '0;
                end else begin
                    idx  <= idx + IDX_ONE;
                    stim <= idx + IDX_ONE;
                    cnt  <= CNT_LOAD;
                end
            end
        end
    end

endmodule
